// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared core constants plus boot loader state and frame constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    // Existing core-wide constants
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INSTRUCTION_BYTES = 4;
    localparam int BYTE_WIDTH        = 8;

    // Number of bytes in the little-endian word-count header of a boot frame
    localparam int BOOT_LEN_BYTES = 4;

    // Boot loader phases; CSUM is only reachable when the checksum option is built
    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        CSUM  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } boot_state_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/boot_loader_if.sv
// ============================================================================
// Module : boot_loader_if
// Brief  : Byte stream (valid/ready) plus instruction RAM write port.
//          master = host/RAM side, slave = boot loader side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface boot_loader_if #(
    parameter int XLEN = 32
);
    import riscv_pkg::*;

    logic [BYTE_WIDTH-1:0]        in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         wr_en;
    logic [XLEN-1:0]              wr_addr;
    logic [INSTRUCTION_WIDTH-1:0] wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface : boot_loader_if

`default_nettype wire

// File: rtl/boot_loader_word_assembler.sv
// ============================================================================
// Module : word_assembler
// Brief  : Collects bytes LSB-first into a word; word_valid_o pulses on the
//          cycle the final byte is accepted, with word_o already complete.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler
    import riscv_pkg::*;
(
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         clear_i,
    input  wire logic                         byte_valid_i,
    input  wire logic [BYTE_WIDTH-1:0]        byte_i,
    output logic      [INSTRUCTION_WIDTH-1:0] word_o,
    output logic                              word_valid_o
);

    localparam int CNT_W = $clog2(INSTRUCTION_BYTES);

    logic [CNT_W-1:0]             cnt_q;
    logic [INSTRUCTION_WIDTH-1:0] shift_q;

    // The newest byte enters at the top, so after the last byte byte 0 sits in the LSBs
    assign word_o       = {byte_i, shift_q[INSTRUCTION_WIDTH-1:BYTE_WIDTH]};
    assign word_valid_o = byte_valid_i && (cnt_q == CNT_W'(INSTRUCTION_BYTES - 1));

    // Byte counter and shift register; the counter wraps naturally after a full word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            shift_q <= word_o;
        end
    end

endmodule : word_assembler

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// Module : boot_loader
// Brief  : Receives a length-prefixed program image over a byte stream and
//          writes it word by word into instruction RAM, holding the core in
//          reset until the image is complete.
//          Optional macro BOOT_LOADER_CHECKSUM_EN appends a one-byte modular
//          sum of all data bytes that must match before the core is released.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    boot_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error
);

    localparam int CW = $clog2(DEPTH_WORDS) + 1;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_t END_STATE = CSUM;
`else
    localparam boot_state_t END_STATE = DONE;
`endif
    // Loader keeps accepting bytes after the data phase only when a checksum follows
    localparam bit END_ACCEPTS = (END_STATE == CSUM);

    boot_state_t                  state_q;
    logic                         in_ready_q;
    logic                         wr_en_q;
    logic [XLEN-1:0]              wr_addr_q;
    logic [INSTRUCTION_WIDTH-1:0] wr_data_q;
    logic                         cpu_hold_q;
    logic                         done_q;
    logic                         error_q;
    logic [CW-1:0]                n_q;
    logic [CW-1:0]                wcnt_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0]        csum_q;
`endif

    logic                         w_accept;
    logic                         w_asm_valid;
    logic                         w_asm_clear;
    logic [INSTRUCTION_WIDTH-1:0] w_asm_word;
    logic                         w_asm_word_valid;
    logic                         w_last_word;
    logic [XLEN-1:0]              w_word_addr;

    assign w_accept    = bus.in_valid && in_ready_q;
    assign w_asm_valid = w_accept && ((state_q == LEN) || (state_q == DATA));
    assign w_asm_clear = !((state_q == LEN) || (state_q == DATA));
    assign w_last_word = ((wcnt_q + CW'(1)) == n_q);
    assign w_word_addr = XLEN'({wcnt_q, 2'b00});

    // Shared assembler: builds the length header first, then each data word
    word_assembler u_word_assembler (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (w_asm_clear),
        .byte_valid_i (w_asm_valid),
        .byte_i       (bus.in_data),
        .word_o       (w_asm_word),
        .word_valid_o (w_asm_word_valid)
    );

    // Frame sequencer with registered handshake, write port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LEN;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            n_q        <= '0;
            wcnt_q     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            // Status follows the state one cycle later, so done rises after the last write
            done_q     <= (state_q == DONE);
            error_q    <= (state_q == ERROR);
            cpu_hold_q <= (state_q != DONE);

            case (state_q)
                LEN: begin
                    in_ready_q <= 1'b1;
                    if (w_asm_word_valid) begin
                        // Range check uses the full 32-bit count before it is narrowed
                        if (w_asm_word == '0) begin
                            state_q    <= END_STATE;
                            in_ready_q <= END_ACCEPTS;
                        end else if (w_asm_word > 32'(DEPTH_WORDS)) begin
                            state_q    <= ERROR;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            n_q     <= w_asm_word[CW-1:0];
                        end
                    end
                end

                DATA: begin
                    in_ready_q <= 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    if (w_accept) begin
                        csum_q <= csum_q + bus.in_data;
                    end
`endif
                    if (w_asm_word_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= w_asm_word;
                        wr_addr_q <= w_word_addr;
                        wcnt_q    <= wcnt_q + CW'(1);
                        if (w_last_word) begin
                            state_q    <= END_STATE;
                            in_ready_q <= END_ACCEPTS;
                        end
                    end
                end

`ifdef BOOT_LOADER_CHECKSUM_EN
                CSUM: begin
                    in_ready_q <= 1'b1;
                    if (w_accept) begin
                        in_ready_q <= 1'b0;
                        state_q    <= (bus.in_data == csum_q) ? DONE : ERROR;
                    end
                end
`endif

                default: begin
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule : boot_loader

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module : tb_boot_loader
// Brief  : Self-checking bench for boot_loader: directed frames plus random
//          images scored against a frame-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_loader;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_hold, done, error;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] obs_q[$];

    always #5 clk = ~clk;

    boot_loader_if #(.XLEN(XLEN)) bus ();

    boot_loader #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    // Write monitor: every cycle with wr_en high is one RAM write {addr, data}
    always @(negedge clk) begin
        if (rst_n && bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: interprets a whole frame from the byte-level rules
    function automatic void model(input logic [7:0] fr[$], output logic [63:0] wq[$],
                                  output logic exp_done, output logic exp_err);
        longint unsigned n;
        int unsigned     sum;
        logic [31:0]     word;
        wq  = {};
        sum = 0;
        n = longint'(fr[0]) + (longint'(fr[1]) << 8) + (longint'(fr[2]) << 16) + (longint'(fr[3]) << 24);
        exp_err = (n > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                word = 0;
                for (int k = 0; k < 4; k++) begin
                    word = word + (32'(fr[4 + 4*i + k]) << (8*k));
                    sum  = sum + fr[4 + 4*i + k];
                end
                wq.push_back({32'(4*i), word});
            end
            if (CSUM_ON) exp_err = (fr[4 + 4*int'(n)] != 8'(sum % 256));
        end
        exp_done = !exp_err;
    endfunction

    function automatic void build_frame(input int unsigned n, input int nwords, input bit bad,
                                        output logic [7:0] fr[$]);
        int unsigned sum;
        logic [7:0]  b;
        fr  = {};
        sum = 0;
        for (int k = 0; k < 4; k++) fr.push_back(8'(n >> (8*k)));
        for (int i = 0; i < nwords*4; i++) begin
            b = 8'($urandom_range(0, 255));
            fr.push_back(b);
            sum = sum + b;
        end
        if (CSUM_ON && n <= DEPTH) fr.push_back(8'(sum + (bad ? 1 : 0)));
    endfunction

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        int k;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (bus.in_ready !== 1'b1) check({tag, " accept timeout"}, 64'(bus.in_ready), 64'd1);
        else @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int maxgap, input string tag);
        for (int i = 0; i < fr.size(); i++)
            send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, tag);
    endtask

    // Wait (bounded) for a terminal outcome, then score writes and status
    task automatic finish_check(input string tag, input logic [7:0] fr[$]);
        logic [63:0] wq[$];
        logic        ed, ee;
        int          k;
        k = 0;
        while (!(done || error) && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        model(fr, wq, ed, ee);
        check({tag, " write count"}, 64'(obs_q.size()), 64'(wq.size()));
        for (int i = 0; i < wq.size() && i < obs_q.size(); i++)
            check($sformatf("%s write %0d", tag, i), obs_q[i], wq[i]);
        check({tag, " done"},     64'(done),     64'(ed));
        check({tag, " error"},    64'(error),    64'(ee));
        check({tag, " cpu_hold"}, 64'(cpu_hold), 64'(!ed));
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, " exclusive"}, 64'(done && error), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
    endtask

    logic [7:0] fr[$];
    logic [7:0] dir[$];
    int unsigned s;

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        check("rst wr_en",    64'(bus.wr_en),    64'd0);
        check("rst wr_addr",  64'(bus.wr_addr),  64'd0);
        check("rst wr_data",  64'(bus.wr_data),  64'd0);
        check("rst cpu_hold", 64'(cpu_hold),     64'd1);
        check("rst done",     64'(done),         64'd0);
        check("rst error",    64'(error),        64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("LEN in_ready", 64'(bus.in_ready), 64'd1);

        // Directed two-word image, back-to-back bytes
        dir = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        s = 0;
        for (int i = 4; i < dir.size(); i++) s = s + dir[i];
        if (CSUM_ON) dir.push_back(8'(s));
        obs_q.delete();
        send_frame(dir, 0, "dir2");
        if (!CSUM_ON) begin
            check("dir2 last wr_en",   64'(bus.wr_en),   64'd1);
            check("dir2 last wr_addr", 64'(bus.wr_addr), 64'h4);
            check("dir2 last wr_data", 64'(bus.wr_data), 64'h00100593);
            check("dir2 done early",   64'(done),        64'd0);
            @(negedge clk);
            check("dir2 done next",     64'(done),     64'd1);
            check("dir2 cpu_hold next", 64'(cpu_hold), 64'd0);
            check("dir2 wr_en single",  64'(bus.wr_en), 64'd0);
        end
        finish_check("dir2", dir);
        check("dir2 word0", obs_q.size() > 0 ? obs_q[0] : 64'd0, {32'h0, 32'h00A00513});

        // Empty image
        do_reset();
        build_frame(0, 0, 1'b0, fr);
        send_frame(fr, 0, "n0");
        finish_check("n0", fr);

        // Oversized image is rejected and further bytes are ignored
        do_reset();
        build_frame(DEPTH + 1, 0, 1'b0, fr);
        send_frame(fr, 0, "over");
        finish_check("over", fr);
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check("over ignore writes", 64'(obs_q.size()), 64'd0);
        check("over ignore error",  64'(error),        64'd1);
        check("over ignore ready",  64'(bus.in_ready), 64'd0);

        // Count that would alias to zero if narrowed before the range check
        do_reset();
        build_frame(32'h0001_0000, 0, 1'b0, fr);
        send_frame(fr, 0, "big");
        finish_check("big", fr);

        // Random three-word image, first without gaps, then with random gaps
        build_frame(3, 3, 1'b0, fr);
        do_reset();
        send_frame(fr, 0, "w3");
        finish_check("w3 nogap", fr);
        do_reset();
        send_frame(fr, 3, "w3g");
        finish_check("w3 gaps", fr);

        // Asynchronous reset in the middle of word 1
        do_reset();
        build_frame(2, 2, 1'b0, fr);
        for (int i = 0; i < 10; i++) send_byte(fr[i], 0, "mid");
        #2 rst_n = 1'b0;
        #1;
        check("mid in_ready", 64'(bus.in_ready), 64'd0);
        check("mid wr_en",    64'(bus.wr_en),    64'd0);
        check("mid wr_addr",  64'(bus.wr_addr),  64'd0);
        check("mid wr_data",  64'(bus.wr_data),  64'd0);
        check("mid cpu_hold", 64'(cpu_hold),     64'd1);
        check("mid done",     64'(done),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
        build_frame(2, 2, 1'b0, fr);
        send_frame(fr, 2, "fresh");
        finish_check("fresh", fr);

        // Largest legal image fills memory up to the last word address
        do_reset();
        build_frame(DEPTH, DEPTH, 1'b0, fr);
        send_frame(fr, 0, "full");
        finish_check("full", fr);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Checksum accepted and rejected for the same one-word image
        dir = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0A};
        do_reset();
        send_frame(dir, 0, "csum ok");
        finish_check("csum ok", dir);
        dir[8] = 8'h0B;
        do_reset();
        send_frame(dir, 0, "csum bad");
        finish_check("csum bad", dir);
        check("csum bad word", obs_q.size() > 0 ? obs_q[0] : 64'd0, {32'h0, 32'h01020304});
        build_frame(2, 2, 1'b1, fr);
        do_reset();
        send_frame(fr, 1, "csum rnd bad");
        finish_check("csum rnd bad", fr);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_boot_loader

`default_nettype wire
